// File: rtl/pic_pkg.sv
// Shared definitions for the PIC host master.
// Contents:
//   - ICW1 bit positions: IC4 (ICW4 needed), SNGL (single PIC, no ICW3),
//     and ICW1_MARK (the bit that identifies an ICW1 write).
//   - state_t, the bus sequencer state encoding.
//   - widx_t, the index of the ICW currently being written.
//   - next_write(), which picks the next ICW from the ICW1 option bits.
package pic_pkg;

  localparam int IC4       = 0;
  localparam int SNGL      = 1;
  localparam int ICW1_MARK = 4;

  typedef enum logic [3:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    W_GAP,
    A_LOW1,
    A_GAP,
    A_LOW2,
    A_DONE
  } state_t;

  typedef logic [1:0] widx_t;

  // Returns {more, next_index} after writing ICW 'cur'.
  // Index 0..3 maps to ICW1..ICW4.
  function automatic logic [2:0] next_write(input widx_t cur, input logic [7:0] icw1);
    logic [2:0] r;
    r = 3'b000;
    case (cur)
      2'd0: r = {1'b1, 2'd1};
      2'd1: begin
        if (!icw1[SNGL])    r = {1'b1, 2'd2};
        else if (icw1[IC4]) r = {1'b1, 2'd3};
      end
      2'd2: if (icw1[IC4]) r = {1'b1, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; the output clears to 0
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pic_host_master.sv
// CPU-side bus master for a programmable interrupt controller.
//
// On an accepted init_start it programs the PIC with the ICW1..ICW4 write
// sequence. ICW3 and ICW4 are skipped according to the ICW1 option bits.
// It answers a synchronized INT with a two-pulse INTA cycle and captures
// the vector that the PIC drives on the second pulse.
//
// Inputs:
//   clk, rst_n (asynchronous, active low)
//   init_start, icw1_in..icw4_in
//   int_enable, INT (asynchronous)
//   data_in
// Bus outputs:
//   cs_n, wr_n, rd_n (held 1), a0, data_out, data_oe
//   INTA, number_of_ack
// Status outputs:
//   init_busy, init_done (pulse), vector_valid (pulse), vector
module pic_host_master
  import pic_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_start,
  input  logic [7:0] icw1_in,
  input  logic [7:0] icw2_in,
  input  logic [7:0] icw3_in,
  input  logic [7:0] icw4_in,
  input  logic       int_enable,
  input  logic       INT,
  input  logic [7:0] data_in,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       INTA,
  output logic [1:0] number_of_ack,
  output logic       init_busy,
  output logic       init_done,
  output logic       vector_valid,
  output logic [7:0] vector
);

  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LD    = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  widx_t      widx;
  logic       initialized;
  logic       armed;
  logic       init_pend;
  logic       int_s;
  logic [7:0] icw_q [4];
  logic       is_write;
  logic       is_ack;
  logic       start_req;
  logic       ack_go;
  logic [2:0] nxt;
  logic [7:0] icw1_marked;

  sync_2ff u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  assign rd_n      = 1'b1;
  assign is_write  = state inside {W_SETUP, W_STROBE, W_HOLD, W_GAP};
  assign is_ack    = state inside {A_LOW1, A_GAP, A_LOW2, A_DONE};
  assign start_req = init_start || init_pend;
  assign ack_go    = initialized && int_enable && int_s && armed;
  assign nxt       = next_write(widx, icw_q[0]);

  // The first write uses the live ICW1 input on a direct accept.
  // It uses the stored copy when servicing a pending request.
  always_comb begin
    icw1_marked            = init_pend ? icw_q[0] : icw1_in;
    icw1_marked[ICW1_MARK] = 1'b1;
  end

  // ICW values are captured with the request. This also covers a request
  // that arrives during an acknowledge and is serviced later. Requests seen
  // during a write sequence are ignored.
  always_ff @(posedge clk) begin
    if (init_start && !init_pend && !is_write) begin
      icw_q[0] <= icw1_in;
      icw_q[1] <= icw2_in;
      icw_q[2] <= icw3_in;
      icw_q[3] <= icw4_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      widx          <= 2'd0;
      cs_n          <= 1'b1;
      wr_n          <= 1'b1;
      a0            <= 1'b0;
      data_out      <= 8'h00;
      data_oe       <= 1'b0;
      INTA          <= 1'b1;
      number_of_ack <= 2'd0;
      init_busy     <= 1'b0;
      init_done     <= 1'b0;
      vector_valid  <= 1'b0;
      vector        <= 8'h00;
      initialized   <= 1'b0;
      armed         <= 1'b0;
      init_pend     <= 1'b0;
    end else begin
      init_done    <= 1'b0;
      vector_valid <= 1'b0;
      if (!int_s) armed <= 1'b1;
      if (is_ack && init_start) init_pend <= 1'b1;

      case (state)
        IDLE: begin
          // An init request beats a simultaneous acknowledge trigger.
          // The INT stays armed and is answered afterwards.
          if (start_req) begin
            state     <= W_SETUP;
            init_pend <= 1'b0;
            widx      <= 2'd0;
            cs_n      <= 1'b0;
            wr_n      <= 1'b1;
            a0        <= 1'b0;
            data_out  <= icw1_marked;
            data_oe   <= 1'b1;
            init_busy <= 1'b1;
          end else if (ack_go) begin
            state         <= A_LOW1;
            INTA          <= 1'b0;
            number_of_ack <= 2'd1;
            cnt           <= STROBE_LD;
          end
        end
        W_SETUP: begin
          state <= W_STROBE;
          wr_n  <= 1'b0;
          cnt   <= STROBE_LD;
        end
        W_STROBE: begin
          if (cnt == 4'd0) begin
            state <= W_HOLD;
            wr_n  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        W_HOLD: begin
          cs_n    <= 1'b1;
          data_oe <= 1'b0;
          if (nxt[2]) begin
            state <= W_GAP;
            widx  <= nxt[1:0];
            cnt   <= GAP_LD;
          end else begin
            state       <= IDLE;
            init_busy   <= 1'b0;
            init_done   <= 1'b1;
            initialized <= 1'b1;
          end
        end
        W_GAP: begin
          if (cnt == 4'd0) begin
            state    <= W_SETUP;
            cs_n     <= 1'b0;
            a0       <= 1'b1;
            data_out <= icw_q[widx];
            data_oe  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        A_LOW1: begin
          if (cnt == 4'd0) begin
            state <= A_GAP;
            INTA  <= 1'b1;
            cnt   <= GAP_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        A_GAP: begin
          if (cnt == 4'd0) begin
            state         <= A_LOW2;
            INTA          <= 1'b0;
            number_of_ack <= 2'd2;
            cnt           <= STROBE_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        A_LOW2: begin
          // The PIC drives the vector while the second pulse is low.
          // It is sampled on the final low cycle.
          if (cnt == 4'd0) begin
            state         <= A_DONE;
            INTA          <= 1'b1;
            number_of_ack <= 2'd0;
            vector        <= data_in;
            vector_valid  <= 1'b1;
            armed         <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        A_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_master.sv
module tb_pic_host_master;

  localparam int S = 2;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_start = 1'b0;
  logic [7:0] icw1_in = 8'h00, icw2_in = 8'h00, icw3_in = 8'h00, icw4_in = 8'h00;
  logic       int_enable = 1'b0;
  logic       INT = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       cs_n, wr_n, rd_n, a0, data_oe, INTA, init_busy, init_done, vector_valid;
  logic [7:0] data_out, vector;
  logic [1:0] number_of_ack;

  pic_host_master #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .icw1_in(icw1_in), .icw2_in(icw2_in), .icw3_in(icw3_in), .icw4_in(icw4_in),
    .int_enable(int_enable), .INT(INT), .data_in(data_in),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .data_out(data_out),
    .data_oe(data_oe), .INTA(INTA), .number_of_ack(number_of_ack),
    .init_busy(init_busy), .init_done(init_done), .vector_valid(vector_valid),
    .vector(vector)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Scoreboard queues: expected writes {a0,data}, vectors, init_done cycles (-1 = untimed)
  logic [8:0] wq[$];
  logic [7:0] vq[$];
  int         dq[$];
  int         done_cnt = 0;
  int         vv_cnt = 0;
  logic [7:0] last_vec = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // Reference write list derived from the ICW1 option bits
  function automatic int push_writes(input logic [7:0] i1, i2, i3, i4);
    int n;
    wq.push_back({1'b0, i1 | 8'h10});
    wq.push_back({1'b1, i2});
    n = 2;
    if (!i1[1]) begin wq.push_back({1'b1, i3}); n++; end
    if (i1[0])  begin wq.push_back({1'b1, i4}); n++; end
    return n;
  endfunction

  // Expected {INTA, number_of_ack, vector_valid} at cycle i of an acknowledge
  function automatic logic [3:0] ack_exp(input int i);
    if (i < S)             return {1'b0, 2'd1, 1'b0};
    else if (i < S + G)    return {1'b1, 2'd1, 1'b0};
    else if (i < 2*S + G)  return {1'b0, 2'd2, 1'b0};
    else                   return {1'b1, 2'd0, 1'b1};
  endfunction

  // Write monitor
  int run = 0, gap = 0;
  logic [8:0] cur_wr;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0; gap = 0;
    end else begin
      if (!wr_n) begin
        run++;
        chk("strobe_cs_oe", {cs_n, data_oe}, 2'b01);
        cur_wr = {a0, data_out};
      end else if (run > 0) begin
        chk("strobe_width", run, S);
        if (wq.size() == 0) fail_now("unexpected_write");
        else chk("write_a0_data", cur_wr, wq.pop_front());
        run = 0;
      end
      if (!init_busy) gap = 0;
      else if (cs_n) gap++;
      else if (gap > 0) begin chk("gap_width", gap, G); gap = 0; end
    end
  end

  // init_done monitor
  int e_done;
  always @(negedge clk) begin
    if (rst_n && init_done) begin
      chk("writes_all_seen", wq.size(), 0);
      if (dq.size() == 0) fail_now("unexpected_init_done");
      else begin
        e_done = dq.pop_front();
        if (e_done >= 0) chk("init_done_cycle", cyc, e_done);
      end
      done_cnt++;
    end
  end

  // Acknowledge monitor
  logic in_ack = 1'b0;
  int   aidx = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_ack = 1'b0; aidx = 0;
    end else begin
      if (!in_ack && !INTA) begin
        in_ack = 1'b1; aidx = 0;
        if (vq.size() == 0) fail_now("unexpected_ack");
      end
      if (in_ack) begin
        chk("ack_pattern", {INTA, number_of_ack, vector_valid}, ack_exp(aidx));
        chk("ack_bus_idle", {cs_n, data_oe}, 2'b10);
        if (aidx == 2*S + G) begin
          if (vq.size() != 0) chk("vector", vector, vq.pop_front());
          vv_cnt++;
          in_ack = 1'b0;
        end else begin
          aidx++;
        end
      end else if (vector_valid) begin
        fail_now("stray_vector_valid");
      end
    end
  end

  task automatic wait_done(input int prev);
    for (int k = 0; k < 400 && done_cnt == prev; k++) @(negedge clk);
    if (done_cnt == prev) fail_now("init_done_timeout");
  endtask

  task automatic wait_vv(input int prev);
    for (int k = 0; k < 400 && vv_cnt == prev; k++) @(negedge clk);
    if (vv_cnt == prev) fail_now("vector_timeout");
  endtask

  task automatic do_init(input logic [7:0] i1, i2, i3, i4);
    int n, prev;
    prev = done_cnt;
    icw1_in = i1; icw2_in = i2; icw3_in = i3; icw4_in = i4;
    init_start = 1'b1;
    @(posedge clk); #1;
    init_start = 1'b0;
    n = push_writes(i1, i2, i3, i4);
    dq.push_back(cyc + n*(2 + S) + (n - 1)*G);
    wait_done(prev);
    chk("vector_kept_by_init", vector, last_vec);
  endtask

  task automatic do_ack(input logic [7:0] v);
    int prev;
    prev = vv_cnt;
    vq.push_back(v);
    data_in = v;
    INT = 1'b1;
    wait_vv(prev);
    last_vec = v;
    repeat (15) @(posedge clk);
    chk("vector_hold", vector, v);
    INT = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic no_ack_window(input string name);
    INT = 1'b1;
    repeat (20) @(negedge clk);
    chk(name, {INTA, number_of_ack, vector}, {1'b1, 2'd0, last_vec});
    INT = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, prevd, n, k;
    logic [7:0] v;

    #12;
    chk("reset_bus", {cs_n, wr_n, rd_n, INTA, a0, data_oe}, 6'b111100);
    chk("reset_data_out", data_out, 8'h00);
    chk("reset_status", {number_of_ack, init_busy, init_done, vector_valid}, 5'd0);
    chk("reset_vector", vector, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // INT before any init
    int_enable = 1'b1;
    no_ack_window("no_ack_uninit");

    // Full four-write init, then single/no-ICW4 init
    do_init(8'h11, 8'h20, 8'h00, 8'h01);
    do_init(8'h02, 8'h48, 8'($urandom), 8'($urandom));

    // int_enable low blocks acknowledge
    int_enable = 1'b0;
    no_ack_window("no_ack_disabled");
    int_enable = 1'b1;

    // Acknowledge with a fixed vector, held INT, then a second edge
    do_ack(8'h4B);
    do_ack(8'($urandom));

    // Randomized init/ack pairs
    for (int i = 0; i < 5; i++) begin
      do_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      do_ack(8'($urandom));
    end

    // init_start during A_GAP is deferred until the acknowledge completes
    prev = vv_cnt;
    v = 8'($urandom);
    vq.push_back(v);
    data_in = v;
    INT = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (INTA && number_of_ack == 2'd1) break;
    end
    if (k == 50) fail_now("a_gap_timeout");
    prevd = done_cnt;
    icw1_in = 8'($urandom); icw2_in = 8'($urandom);
    icw3_in = 8'($urandom); icw4_in = 8'($urandom);
    init_start = 1'b1;
    n = push_writes(icw1_in, icw2_in, icw3_in, icw4_in);
    dq.push_back(-1);
    @(posedge clk); #1;
    init_start = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (vector_valid) break;
    end
    if (k == 50) fail_now("pend_vv_timeout");
    last_vec = v;
    @(negedge clk);
    chk("pend_idle_cycle", {cs_n, init_busy}, 2'b10);
    @(negedge clk);
    chk("pend_setup_cycle", {cs_n, init_busy}, 2'b01);
    wait_done(prevd);
    INT = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Asynchronous reset in the middle of a write strobe
    icw1_in = 8'h11; icw2_in = 8'h20; icw3_in = 8'h00; icw4_in = 8'h01;
    init_start = 1'b1;
    @(posedge clk); #1;
    init_start = 1'b0;
    n = push_writes(8'h11, 8'h20, 8'h00, 8'h01);
    dq.push_back(-1);
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!wr_n) break;
    end
    if (k == 30) fail_now("strobe_timeout");
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_bus", {wr_n, cs_n, data_oe, INTA, init_busy}, 5'b11010);
    wq.delete();
    dq.delete();
    repeat (2) @(posedge clk); #1;
    chk("reset_vector_cleared", vector, 8'h00);
    last_vec = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    no_ack_window("no_ack_after_reset");

    do_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    do_ack(8'($urandom));

    chk("queues_empty", wq.size() + vq.size() + dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
